// File: rtl/jt1943_objbuf_line.sv
// Double-buffered sprite line buffer: one bank is drawn while the other is replayed
// to the colour mixer and erased behind the read. Optional JT1943_OBJBUF_FIRSTWIN_EN
// gives first-write-wins priority instead of last-write-wins.
module jt1943_objbuf_line #(
    parameter int               PXLW   = 8,
    parameter logic [3:0]       TRANSP = 4'hF,
    parameter logic [PXLW-1:0]  BLANK  = {PXLW{1'b1}}
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            cen6,
    input  logic            HINIT,
    input  logic [8:0]      H,
    input  logic [8:0]      posx,
    input  logic [PXLW-1:0] new_pxl,
    output logic [PXLW-1:0] obj_pxl,
    output logic            clr_busy
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]      state;
    logic [8:0]      cnt;
    logic            rd_bank;
    logic            wr_bank;
    logic            wr_en;
    logic [PXLW-1:0] rd_word;

    logic [PXLW-1:0] bank0 [0:255];
    logic [PXLW-1:0] bank1 [0:255];

    logic            we0, we1;
    logic [7:0]      a0, a1;
    logic [PXLW-1:0] d0, d1;

    assign wr_bank  = ~rd_bank;
    assign clr_busy = (state == ST_CLEAR);
    assign rd_word  = rd_bank ? bank1[H[7:0]] : bank0[H[7:0]];

`ifdef JT1943_OBJBUF_FIRSTWIN_EN
    // Only land on an entry that still holds a transparent pixel.
    logic [3:0] wr_cur_lo;
    assign wr_cur_lo = wr_bank ? bank1[posx[7:0]][3:0] : bank0[posx[7:0]][3:0];
    assign wr_en = !posx[8] && (new_pxl[3:0] != TRANSP) && (wr_cur_lo == TRANSP);
`else
    assign wr_en = !posx[8] && (new_pxl[3:0] != TRANSP);
`endif

    // Draw writes always hit wr_bank and erases hit rd_bank, so each bank sees at most one write.
    always_comb begin
        we0 = 1'b0;
        we1 = 1'b0;
        a0  = cnt[7:0];
        a1  = cnt[7:0];
        d0  = BLANK;
        d1  = BLANK;
        if (state == ST_CLEAR) begin
            we0 = ~cnt[8];
            we1 = cnt[8];
        end else if (cen6) begin
            if (wr_en) begin
                if (wr_bank) begin
                    we1 = 1'b1;
                    a1  = posx[7:0];
                    d1  = new_pxl;
                end else begin
                    we0 = 1'b1;
                    a0  = posx[7:0];
                    d0  = new_pxl;
                end
            end
            if (!H[8]) begin
                if (rd_bank) begin
                    we1 = 1'b1;
                    a1  = H[7:0];
                    d1  = BLANK;
                end else begin
                    we0 = 1'b1;
                    a0  = H[7:0];
                    d0  = BLANK;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we0) bank0[a0] <= d0;
    end

    always_ff @(posedge clk) begin
        if (we1) bank1[a1] <= d1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_CLEAR;
            cnt     <= 9'd0;
            rd_bank <= 1'b0;
            obj_pxl <= BLANK;
        end else if (state == ST_CLEAR) begin
            cnt     <= cnt + 9'd1;
            obj_pxl <= BLANK;
            if (cnt == 9'd511) state <= ST_RUN;
        end else if (cen6) begin
            if (HINIT) rd_bank <= ~rd_bank;
            obj_pxl <= H[8] ? BLANK : rd_word;
        end
    end

endmodule

// File: tb/tb_jt1943_objbuf_line.sv
// Directed bench for jt1943_objbuf_line: clear sweep timing, draw/replay/erase,
// transparency, posx[8] discard, overwrite priority, HINIT timing and mid-sweep reset.
module tb_jt1943_objbuf_line;

    logic       rst, clk, cen6, HINIT;
    logic [8:0] H, posx;
    logic [7:0] new_pxl, obj_pxl;
    logic       clr_busy;

    int checks = 0;
    int errors = 0;
    int n_busy;
    bit pxl_ok;

    jt1943_objbuf_line dut (
        .rst      (rst),
        .clk      (clk),
        .cen6     (cen6),
        .HINIT    (HINIT),
        .H        (H),
        .posx     (posx),
        .new_pxl  (new_pxl),
        .obj_pxl  (obj_pxl),
        .clr_busy (clr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        cen6 = 1'b0; HINIT = 1'b0; H = 9'h100; posx = 9'h100; new_pxl = 8'h00;
    endtask

    // One cen6 step: inputs applied for the enabled edge, then three disabled clocks.
    task automatic tick(input logic hinit, input logic [8:0] h, input logic [8:0] px,
                        input logic [7:0] pix);
        HINIT = hinit; H = h; posx = px; new_pxl = pix; cen6 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
    endtask

    task automatic sweep(input string tag, input logic [7:0] hit_addr, input logic [7:0] hit_val);
        for (int h = 0; h < 256; h++) begin
            tick(1'b0, {1'b0, h[7:0]}, 9'h100, 8'h00);
            check(tag, {24'd0, obj_pxl}, (h[7:0] == hit_addr) ? {24'd0, hit_val} : 32'h0000_00FF);
        end
        tick(1'b0, 9'h100, 9'h100, 8'h00);
        check({tag, "_hblank"}, {24'd0, obj_pxl}, 32'h0000_00FF);
    endtask

    // Counts negedge samples with clr_busy high; optionally pokes HINIT/draw mid-sweep.
    task automatic wait_clear(input bit poke, output int n, output bit ok);
        n = 0; ok = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (!clr_busy) break;
            n++;
            if (obj_pxl !== 8'hFF) ok = 1'b0;
            if (poke && i >= 300 && i <= 302) begin
                cen6 = 1'b1; HINIT = 1'b1; posx = 9'h020; new_pxl = 8'h66; H = 9'h020;
            end else begin
                idle();
            end
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_obj_pxl", {24'd0, obj_pxl}, 32'h0000_00FF);
        check("rst_clr_busy", {31'd0, clr_busy}, 32'd1);
        rst = 1'b0;

        wait_clear(1'b1, n_busy, pxl_ok);
        check("clear_len", n_busy, 32'd512);
        check("clear_pxl_blank", {31'd0, pxl_ok}, 32'd1);
        check("clear_done", {31'd0, clr_busy}, 32'd0);

        // Nothing written or swapped during the clear: both banks read back blank.
        tick(1'b1, 9'h100, 9'h100, 8'h00);
        sweep("post_clear", 8'h00, 8'hFF);

        tick(1'b0, 9'h100, 9'h010, 8'h23);
        tick(1'b1, 9'h100, 9'h100, 8'h00);
        sweep("basic", 8'h10, 8'h23);
        sweep("erased", 8'h10, 8'hFF);

        tick(1'b0, 9'h100, 9'h005, 8'h5F);
        tick(1'b0, 9'h100, 9'h105, 8'h77);
        tick(1'b1, 9'h100, 9'h100, 8'h00);
        sweep("transp_posx8", 8'h05, 8'hFF);

        tick(1'b0, 9'h100, 9'd40, 8'h12);
        tick(1'b0, 9'h100, 9'd40, 8'h34);
        tick(1'b1, 9'h100, 9'h100, 8'h00);
`ifdef JT1943_OBJBUF_FIRSTWIN_EN
        sweep("priority", 8'd40, 8'h12);
`else
        sweep("priority", 8'd40, 8'h34);
`endif

        // HINIT with a write and a read in the same step: both use the pre-swap banks.
        tick(1'b1, 9'h007, 9'h007, 8'h41);
        check("hinit_same_read", {24'd0, obj_pxl}, 32'h0000_00FF);
        sweep("hinit_same_write", 8'h07, 8'h41);

        // Reset in the middle of the clear sweep restarts it from zero.
        tick(1'b0, 9'h100, 9'h009, 8'h2A);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("mid_clear_busy", {31'd0, clr_busy}, 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_clear(1'b0, n_busy, pxl_ok);
        check("reclear_len", n_busy, 32'd512);
        check("reclear_pxl_blank", {31'd0, pxl_ok}, 32'd1);
        sweep("reclear_bank", 8'h09, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
